bank_xbar_arb: RTL and testbench

- Round-robin arbiter that shares one cache bank's hit-test unit request port between the 4 xbar channels.
- Sits between the per-channel xbar request queues and the bank HTU input (valid/ready, ch_id, opcode, addr[31:4], wbuffer_id).
- Registers the winning request in a single output stage, so every HTU input comes straight from a flop.
- Sustains 1 request/cycle.

---
 rtl/bank_pkg.sv | 16 +
 rtl/bank_arb_rr_pick.sv | 35 +++
 rtl/bank_xbar_arb.sv | 90 +++++++++
 tb/tb_bank_xbar_arb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - shared constants for the cache bank request path
// Contents: opcode encodings, channel count, address field bounds and
// write-buffer id width used by the bank crossbar arbiter.
package bank_pkg;

   localparam logic [1:0] BANK_OP_READ  = 2'b00;
   localparam logic [1:0] BANK_OP_WRITE = 2'b01;
   localparam logic [1:0] BANK_OP_FLUSH = 2'b10;
   localparam logic [1:0] BANK_OP_INVAL = 2'b11;

   localparam int BANK_CH_NUM   = 4;
   localparam int BANK_ADDR_LSB = 4;
   localparam int BANK_ADDR_MSB = 31;
   localparam int WBID_W        = 8;

endpackage

// File: rtl/bank_arb_rr_pick.sv
// rtl/bank_arb_rr_pick.sv - combinational 4-way round-robin pick
// Ports:
//   req          in  4  requesting channels (already class-filtered)
//   ptr          in  2  highest-priority channel this cycle
//   grant_onehot out 4  one-hot winner, zero when req is zero
//   grant_id     out 2  binary winner, zero when req is zero
module bank_arb_rr_pick
   import bank_pkg::*;
(
   input  logic [BANK_CH_NUM-1:0] req,
   input  logic [1:0]             ptr,
   output logic [BANK_CH_NUM-1:0] grant_onehot,
   output logic [1:0]             grant_id
);

   logic       found;
   logic [1:0] idx;

   // Walk ptr, ptr+1, ... with natural 2-bit wrap; the first hit wins.
   always_comb begin
      grant_onehot = '0;
      grant_id     = '0;
      found        = 1'b0;
      idx          = '0;
      for (int i = 0; i < BANK_CH_NUM; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            found             = 1'b1;
            grant_onehot[idx] = 1'b1;
            grant_id          = idx;
         end
      end
   end

endmodule

// File: rtl/bank_xbar_arb.sv
// rtl/bank_xbar_arb.sv - round-robin arbiter from 4 xbar channels to one bank HTU port
// Optional macro BANK_XBAR_ARB_MAINT_PRIO_EN: flush/invalidate requests win
// over read/write; round-robin then runs among maintenance requesters only.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   ch_valid_i/ch_ready_o per-channel request handshake (ready one-hot or zero)
//   ch_opcode_i           4 x 2-bit opcode, channel k at [2k+1:2k]
//   ch_addr_i             4 x addr[31:4], channel k at [28k+27:28k]
//   ch_wbuffer_id_i       4 x WBID_W write-buffer id
//   htu_valid_o/ready_i   registered request handshake to the hit-test unit
//   htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_wbuffer_id_o  registered payload
module bank_xbar_arb #(
   parameter int CH_NUM = 4,
   parameter int WBID_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [CH_NUM-1:0]    ch_valid_i,
   output logic [CH_NUM-1:0]    ch_ready_o,
   input  logic [CH_NUM*2-1:0]  ch_opcode_i,
   input  logic [CH_NUM*28-1:0] ch_addr_i,
   input  logic [CH_NUM*WBID_W-1:0] ch_wbuffer_id_i,
   output logic                 htu_valid_o,
   input  logic                 htu_ready_i,
   output logic [1:0]           htu_ch_id_o,
   output logic [1:0]           htu_opcode_o,
   output logic [27:0]          htu_addr_o,
   output logic [WBID_W-1:0]    htu_wbuffer_id_o
);

   import bank_pkg::*;

   localparam int AW = BANK_ADDR_MSB - BANK_ADDR_LSB + 1;

   logic [1:0]        rr_ptr;
   logic [CH_NUM-1:0] req;
   logic [CH_NUM-1:0] grant_onehot;
   logic [1:0]        grant_id;
   logic              load;

`ifdef BANK_XBAR_ARB_MAINT_PRIO_EN
   logic [CH_NUM-1:0] maint_req;

   always_comb begin
      maint_req = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         maint_req[k] = ch_valid_i[k] &&
                        (ch_opcode_i[2*k +: 2] == BANK_OP_FLUSH ||
                         ch_opcode_i[2*k +: 2] == BANK_OP_INVAL);
      end
   end

   // Maintenance traffic forms its own class; fall back to everyone otherwise.
   assign req = (|maint_req) ? maint_req : ch_valid_i;
`else
   assign req = ch_valid_i;
`endif

   bank_arb_rr_pick u_pick (
      .req          (req),
      .ptr          (rr_ptr),
      .grant_onehot (grant_onehot),
      .grant_id     (grant_id)
   );

   // rst_i gates load so nothing handshakes while reset is held, even between edges.
   assign load       = rst_i && (|ch_valid_i) && (!htu_valid_o || htu_ready_i);
   assign ch_ready_o = grant_onehot & {CH_NUM{load}};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         htu_valid_o      <= 1'b0;
         htu_ch_id_o      <= '0;
         htu_opcode_o     <= '0;
         htu_addr_o       <= '0;
         htu_wbuffer_id_o <= '0;
         rr_ptr           <= '0;
      end else if (load) begin
         htu_valid_o      <= 1'b1;
         htu_ch_id_o      <= grant_id;
         htu_opcode_o     <= ch_opcode_i[2*grant_id +: 2];
         htu_addr_o       <= ch_addr_i[AW*grant_id +: AW];
         htu_wbuffer_id_o <= ch_wbuffer_id_i[WBID_W*grant_id +: WBID_W];
         rr_ptr           <= grant_id + 2'd1;
      end else if (htu_ready_i) begin
         htu_valid_o      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bank_xbar_arb.sv
// tb/tb_bank_xbar_arb.sv - self-checking bench for bank_xbar_arb
module tb_bank_xbar_arb;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [3:0]   ch_valid_i;
   logic [3:0]   ch_ready_o;
   logic [7:0]   ch_opcode_i;
   logic [111:0] ch_addr_i;
   logic [31:0]  ch_wbuffer_id_i;
   logic         htu_valid_o;
   logic         htu_ready_i;
   logic [1:0]   htu_ch_id_o;
   logic [1:0]   htu_opcode_o;
   logic [27:0]  htu_addr_o;
   logic [7:0]   htu_wbuffer_id_o;

   int vectors = 0;
   int errors  = 0;

   bank_xbar_arb #(.CH_NUM(4), .WBID_W(8)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ch_valid_i       (ch_valid_i),
      .ch_ready_o       (ch_ready_o),
      .ch_opcode_i      (ch_opcode_i),
      .ch_addr_i        (ch_addr_i),
      .ch_wbuffer_id_i  (ch_wbuffer_id_i),
      .htu_valid_o      (htu_valid_o),
      .htu_ready_i      (htu_ready_i),
      .htu_ch_id_o      (htu_ch_id_o),
      .htu_opcode_o     (htu_opcode_o),
      .htu_addr_o       (htu_addr_o),
      .htu_wbuffer_id_o (htu_wbuffer_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ch(input int k, input logic v, input logic [1:0] op,
                         input logic [27:0] a, input logic [7:0] w);
      ch_valid_i[k]           = v;
      ch_opcode_i[2*k +: 2]   = op;
      ch_addr_i[28*k +: 28]   = a;
      ch_wbuffer_id_i[8*k +: 8] = w;
   endtask

   task automatic clear_inputs;
      ch_valid_i      = '0;
      ch_opcode_i     = '0;
      ch_addr_i       = '0;
      ch_wbuffer_id_i = '0;
   endtask

   task automatic apply_reset;
      rst_i = 1'b0;
      clear_inputs();
      htu_ready_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      rst_i           = 1'b0;
      ch_valid_i      = 4'hF;
      ch_opcode_i     = 8'hE4;
      ch_addr_i       = {4{28'hFFFFFFF}};
      ch_wbuffer_id_i = 32'hFFFF_FFFF;
      htu_ready_i     = 1'b1;
      tick();
      tick();
      vectors++; if (htu_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", htu_valid_o); end
      vectors++; if ({htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_wbuffer_id_o} !== 40'd0) begin errors++; $display("FAIL reset_payload: got %h want 0", {htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_wbuffer_id_o}); end
      vectors++; if (ch_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ch_ready: got %b want 0000", ch_ready_o); end
      rst_i = 1'b1;
      clear_inputs();
      set_ch(1, 1'b1, 2'b01, 28'hABCDEF1, 8'h5A);
      #1;
      vectors++; if (ch_ready_o !== 4'b0010) begin errors++; $display("FAIL first_req_ready: got %b want 0010", ch_ready_o); end
      tick();
      clear_inputs();
      vectors++; if (htu_valid_o !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b want 1", htu_valid_o); end
      vectors++; if (htu_ch_id_o !== 2'd1) begin errors++; $display("FAIL first_req_ch_id: got %0d want 1", htu_ch_id_o); end
      vectors++; if ({htu_opcode_o, htu_addr_o, htu_wbuffer_id_o} !== {2'b01, 28'hABCDEF1, 8'h5A}) begin errors++; $display("FAIL first_req_payload: got %h want %h", {htu_opcode_o, htu_addr_o, htu_wbuffer_id_o}, {2'b01, 28'hABCDEF1, 8'h5A}); end
   endtask

   task automatic test_round_robin;
      apply_reset();
      for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 2'(k), 28'(32'h100 + k), 8'(k));
      htu_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [3:0] exp_rdy;
         exp_rdy = 4'(1 << (i % 4));
         #1;
         vectors++; if (ch_ready_o !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ch_ready_o, exp_rdy); end
         tick();
         vectors++; if (htu_valid_o !== 1'b1 || htu_ch_id_o !== 2'(i % 4)) begin errors++; $display("FAIL rr_ch_id[%0d]: got v=%b id=%0d want v=1 id=%0d", i, htu_valid_o, htu_ch_id_o, i % 4); end
         vectors++; if (htu_addr_o !== 28'(32'h100 + i % 4)) begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", i, htu_addr_o, 28'(32'h100 + i % 4)); end
      end
      clear_inputs();
   endtask

   task automatic test_stall;
      apply_reset();
      set_ch(2, 1'b1, 2'b00, 28'h0000123, 8'h22);
      htu_ready_i = 1'b1;
      #1;
      vectors++; if (ch_ready_o !== 4'b0100) begin errors++; $display("FAIL stall_grant_ch2: got %b want 0100", ch_ready_o); end
      tick();
      clear_inputs();
      set_ch(0, 1'b1, 2'b00, 28'h0000AAA, 8'h10);
      set_ch(3, 1'b1, 2'b01, 28'h0000333, 8'h33);
      htu_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (ch_ready_o !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, ch_ready_o); end
         tick();
         vectors++; if ({htu_valid_o, htu_ch_id_o, htu_addr_o} !== {1'b1, 2'd2, 28'h0000123}) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b id=%0d addr=%h want v=1 id=2 addr=0000123", i, htu_valid_o, htu_ch_id_o, htu_addr_o); end
      end
      htu_ready_i = 1'b1;
      #1;
      vectors++; if (ch_ready_o !== 4'b1000) begin errors++; $display("FAIL stall_release_ready: got %b want 1000", ch_ready_o); end
      tick();
      vectors++; if ({htu_valid_o, htu_ch_id_o, htu_addr_o} !== {1'b1, 2'd3, 28'h0000333}) begin errors++; $display("FAIL stall_refill: got v=%b id=%0d addr=%h want v=1 id=3 addr=0000333", htu_valid_o, htu_ch_id_o, htu_addr_o); end
      clear_inputs();
   endtask

   task automatic test_wrap;
      apply_reset();
      set_ch(3, 1'b1, 2'b00, 28'h0000E03, 8'h03);
      htu_ready_i = 1'b1;
      #1;
      vectors++; if (ch_ready_o !== 4'b1000) begin errors++; $display("FAIL wrap_ch3_ready: got %b want 1000", ch_ready_o); end
      tick();
      vectors++; if (htu_ch_id_o !== 2'd3) begin errors++; $display("FAIL wrap_ch3_id: got %0d want 3", htu_ch_id_o); end
      set_ch(0, 1'b1, 2'b00, 28'h0000E00, 8'h00);
      #1;
      vectors++; if (ch_ready_o !== 4'b0001) begin errors++; $display("FAIL wrap_ch0_ready: got %b want 0001", ch_ready_o); end
      tick();
      vectors++; if (htu_ch_id_o !== 2'd0) begin errors++; $display("FAIL wrap_ch0_id: got %0d want 0", htu_ch_id_o); end
      clear_inputs();
   endtask

   task automatic test_maint_prio;
      int first;
      int second;
`ifdef BANK_XBAR_ARB_MAINT_PRIO_EN
      first  = 2;
      second = 0;
`else
      first  = 0;
      second = 2;
`endif
      apply_reset();
      set_ch(0, 1'b1, 2'b00, 28'h0000F00, 8'h40);
      set_ch(2, 1'b1, 2'b10, 28'h0000F02, 8'h42);
      htu_ready_i = 1'b1;
      #1;
      vectors++; if (ch_ready_o !== 4'(1 << first)) begin errors++; $display("FAIL maint_first_ready: got %b want %b", ch_ready_o, 4'(1 << first)); end
      tick();
      vectors++; if (htu_ch_id_o !== 2'(first)) begin errors++; $display("FAIL maint_first_id: got %0d want %0d", htu_ch_id_o, first); end
      ch_valid_i[first] = 1'b0;
      #1;
      vectors++; if (ch_ready_o !== 4'(1 << second)) begin errors++; $display("FAIL maint_second_ready: got %b want %b", ch_ready_o, 4'(1 << second)); end
      tick();
      vectors++; if (htu_ch_id_o !== 2'(second)) begin errors++; $display("FAIL maint_second_id: got %0d want %0d", htu_ch_id_o, second); end
      clear_inputs();
   endtask

   task automatic test_async_reset;
      apply_reset();
      set_ch(1, 1'b1, 2'b01, 28'h0000B01, 8'h11);
      htu_ready_i = 1'b1;
      tick();
      clear_inputs();
      htu_ready_i = 1'b0;
      #1;
      vectors++; if (htu_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre_stall: got %b want 1", htu_valid_o); end
      ch_valid_i  = 4'hF;
      htu_ready_i = 1'b1;
      rst_i       = 1'b0;
      #1;
      vectors++; if (htu_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid_drop: got %b want 0", htu_valid_o); end
      vectors++; if (ch_ready_o !== 4'b0000) begin errors++; $display("FAIL areset_ready: got %b want 0000", ch_ready_o); end
      tick();
      rst_i = 1'b1;
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (htu_valid_o !== 1'b0) begin errors++; $display("FAIL areset_stale[%0d]: got %b want 0", i, htu_valid_o); end
      end
   endtask

   // Reference model: a queue-free view of the output slot plus an integer
   // rotation pointer; the winner is the first eligible channel counting
   // upward from the pointer modulo 4.
   task automatic test_random;
      logic        pv[4];
      logic [1:0]  r_op[4];
      logic [27:0] r_addr[4];
      logic [7:0]  r_wb[4];
      logic        m_valid;
      int          m_ch;
      logic [1:0]  m_op;
      logic [27:0] m_addr;
      logic [7:0]  m_wb;
      int          m_rr;
      apply_reset();
      m_valid = 1'b0; m_ch = 0; m_op = '0; m_addr = '0; m_wb = '0; m_rr = 0;
      for (int k = 0; k < 4; k++) pv[k] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bit   elig[4];
         bit   any_maint;
         int   win;
         bit   load;
         logic [3:0] exp_rdy;
         for (int k = 0; k < 4; k++) begin
            if (!pv[k] && $urandom_range(0, 2) == 0) begin
               pv[k]     = 1'b1;
               r_op[k]   = 2'($urandom);
               r_addr[k] = 28'($urandom);
               r_wb[k]   = 8'($urandom);
            end
            set_ch(k, pv[k], r_op[k], r_addr[k], r_wb[k]);
         end
         htu_ready_i = ($urandom_range(0, 3) != 0);
         any_maint = 1'b0;
         for (int k = 0; k < 4; k++) if (pv[k] && r_op[k] >= 2) any_maint = 1'b1;
         for (int k = 0; k < 4; k++) begin
            elig[k] = pv[k];
`ifdef BANK_XBAR_ARB_MAINT_PRIO_EN
            if (any_maint && r_op[k] < 2) elig[k] = 1'b0;
`endif
         end
         win = -1;
         for (int i = 0; i < 4; i++) if (win < 0 && elig[(m_rr + i) % 4]) win = (m_rr + i) % 4;
         load    = (win >= 0) && (!m_valid || htu_ready_i);
         exp_rdy = load ? 4'(1 << win) : 4'b0000;
         #1;
         vectors++; if (ch_ready_o !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, ch_ready_o, exp_rdy); end
         tick();
         if (load) begin
            m_valid = 1'b1;
            m_ch    = win;
            m_op    = r_op[win];
            m_addr  = r_addr[win];
            m_wb    = r_wb[win];
            m_rr    = (win + 1) % 4;
            pv[win] = 1'b0;
         end else if (htu_ready_i) begin
            m_valid = 1'b0;
         end
         vectors++; if (htu_valid_o !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, htu_valid_o, m_valid); end
         if (m_valid) begin
            vectors++; if ({htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_wbuffer_id_o} !== {2'(m_ch), m_op, m_addr, m_wb}) begin errors++; $display("FAIL rand_payload[%0d]: got %h want %h", cyc, {htu_ch_id_o, htu_opcode_o, htu_addr_o, htu_wbuffer_id_o}, {2'(m_ch), m_op, m_addr, m_wb}); end
         end
      end
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_i       = 1'b0;
      htu_ready_i = 1'b0;
      clear_inputs();
      #2;
      test_reset();
      test_round_robin();
      test_stall();
      test_wrap();
      test_maint_prio();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
